// File: rtl/cache_pkg.sv
// Shared constants, state encoding and helpers for the direct-mapped cache controller.
package cache_pkg;

  localparam int TAG_W  = 5;
  localparam int WORD_W = 2;
  localparam int DATA_W = 16;

  // CPU/memory address layout, LSB first: word offset, then set index, then tag.
  localparam int WORD_LSB = 0;
  localparam int IDX_LSB  = WORD_LSB + WORD_W;

  localparam logic [DATA_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PROBE     = 3'd1,
    WRITE_HIT = 3'd2,
    WB_RD     = 3'd3,
    WB_MEM    = 3'd4,
    FILL_MEM  = 3'd5,
    FILL_WR   = 3'd6,
    DONE      = 3'd7
  } state_t;

  // Tag field starts right above the set index, whose width is a module parameter.
  function automatic int tag_lsb(input int idx_w);
    return IDX_LSB + idx_w;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_controller.sv
// Direct-mapped cache controller: probes an external set, writes back dirty
// victims word by word, fills from memory, then replays the probe.
module cache_controller
  import cache_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDX_W = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  // CPU side
  input  logic                            cpu_req,
  input  logic                            cpu_wr,
  input  logic [TAG_W+IDX_W+WORD_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]               cpu_wdata,
  output logic [DATA_W-1:0]               cpu_rdata,
  output logic                            cpu_ack,
  // Set command
  output logic [IDX_W-1:0]                set_index,
  output logic                            set_enable,
  output logic                            set_comp,
  output logic                            set_write,
  output logic                            set_valid_in,
  output logic [WORD_W-1:0]               set_word,
  output logic [TAG_W-1:0]                set_tag_in,
  output logic [DATA_W-1:0]               set_data_in,
  // Set status / read-back
  input  logic                            set_hit,
  input  logic                            set_dirty,
  input  logic                            set_valid,
  input  logic                            set_ack,
  input  logic [TAG_W-1:0]                set_tag_out,
  input  logic [DATA_W-1:0]               set_data_out,
  // Memory side
  output logic                            mem_req,
  output logic                            mem_wr,
  output logic [TAG_W+IDX_W+WORD_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
  input  logic                            mem_ack,
  // Statistics
  output logic [DATA_W-1:0]               hit_cnt,
  output logic [DATA_W-1:0]               miss_cnt
);

  localparam int TAG_LSB = tag_lsb(IDX_W);
  localparam int CNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  state_t               state_r;
  logic [TAG_W-1:0]     req_tag_r;
  logic [IDX_W-1:0]     req_idx_r;
  logic [WORD_W-1:0]    req_word_r;
  logic                 req_wr_r;
  logic [DATA_W-1:0]    req_wdata_r;
  logic [TAG_W-1:0]     victim_tag_r;
  logic [CNT_W-1:0]     word_cnt_r;
  logic                 set_busy_r;   // a set command is outstanding
  logic                 mem_busy_r;   // a memory command is outstanding
  logic                 replay_r;     // current probe follows a fill

  logic                 probe_hit_s;
  logic                 last_word_s;
  logic [WORD_W-1:0]    beat_word_s;

  assign probe_hit_s = set_hit & set_valid;
  assign last_word_s = (word_cnt_r == LAST_WORD);
  assign beat_word_s = WORD_W'(word_cnt_r);

  // Controller FSM with registered command outputs, word counter and statistics.
  // Each command state raises its strobe when idle, holds it until the
  // acknowledge, then drops it; entering the next state costs one more cycle,
  // which gives set_enable its mandatory low cycle between commands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      req_tag_r    <= '0;
      req_idx_r    <= '0;
      req_word_r   <= '0;
      req_wr_r     <= 1'b0;
      req_wdata_r  <= '0;
      victim_tag_r <= '0;
      word_cnt_r   <= '0;
      set_busy_r   <= 1'b0;
      mem_busy_r   <= 1'b0;
      replay_r     <= 1'b0;
      cpu_rdata    <= '0;
      cpu_ack      <= 1'b0;
      set_index    <= '0;
      set_enable   <= 1'b0;
      set_comp     <= 1'b0;
      set_write    <= 1'b0;
      set_valid_in <= 1'b0;
      set_word     <= '0;
      set_tag_in   <= '0;
      set_data_in  <= '0;
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cpu_req) begin
            req_tag_r   <= cpu_addr[TAG_LSB +: TAG_W];
            req_idx_r   <= cpu_addr[IDX_LSB +: IDX_W];
            req_word_r  <= cpu_addr[WORD_LSB +: WORD_W];
            req_wr_r    <= cpu_wr;
            req_wdata_r <= cpu_wdata;
            set_index   <= cpu_addr[IDX_LSB +: IDX_W];
            replay_r    <= 1'b0;
            state_r     <= PROBE;
          end else begin
            state_r <= IDLE;
          end
        end

        PROBE: begin
          if (!set_busy_r) begin
            set_enable   <= 1'b1;
            set_comp     <= 1'b1;
            set_write    <= 1'b0;
            set_valid_in <= 1'b0;
            set_word     <= req_word_r;
            set_tag_in   <= req_tag_r;
            set_busy_r   <= 1'b1;
          end else if (set_ack) begin
            set_enable <= 1'b0;
            set_comp   <= 1'b0;
            set_busy_r <= 1'b0;
            if (probe_hit_s) begin
              if (!replay_r) begin
                hit_cnt <= sat_inc(hit_cnt);
              end
              if (req_wr_r) begin
                state_r <= WRITE_HIT;
              end else begin
                cpu_rdata <= set_data_out;
                cpu_ack   <= 1'b1;
                state_r   <= DONE;
              end
            end else begin
              if (!replay_r) begin
                miss_cnt <= sat_inc(miss_cnt);
              end
              word_cnt_r <= '0;
              state_r    <= (set_valid & set_dirty) ? WB_RD : FILL_MEM;
            end
          end else begin
            state_r <= PROBE;
          end
        end

        WRITE_HIT: begin
          if (!set_busy_r) begin
            set_enable   <= 1'b1;
            set_comp     <= 1'b1;
            set_write    <= 1'b1;
            set_valid_in <= 1'b0;
            set_word     <= req_word_r;
            set_tag_in   <= req_tag_r;
            set_data_in  <= req_wdata_r;
            set_busy_r   <= 1'b1;
          end else if (set_ack) begin
            set_enable <= 1'b0;
            set_comp   <= 1'b0;
            set_write  <= 1'b0;
            set_busy_r <= 1'b0;
            cpu_ack    <= 1'b1;
            state_r    <= DONE;
          end else begin
            state_r <= WRITE_HIT;
          end
        end

        WB_RD: begin
          if (!set_busy_r) begin
            set_enable   <= 1'b1;
            set_comp     <= 1'b0;
            set_write    <= 1'b0;
            set_valid_in <= 1'b0;
            set_word     <= beat_word_s;
            set_busy_r   <= 1'b1;
          end else if (set_ack) begin
            set_enable <= 1'b0;
            set_busy_r <= 1'b0;
            if (word_cnt_r == '0) begin
              victim_tag_r <= set_tag_out;
            end
            mem_wdata <= set_data_out;
            state_r   <= WB_MEM;
          end else begin
            state_r <= WB_RD;
          end
        end

        WB_MEM: begin
          if (!mem_busy_r) begin
            mem_req    <= 1'b1;
            mem_wr     <= 1'b1;
            mem_addr   <= {victim_tag_r, req_idx_r, beat_word_s};
            mem_busy_r <= 1'b1;
          end else if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_busy_r <= 1'b0;
            if (last_word_s) begin
              word_cnt_r <= '0;
              state_r    <= FILL_MEM;
            end else begin
              word_cnt_r <= word_cnt_r + CNT_W'(1);
              state_r    <= WB_RD;
            end
          end else begin
            state_r <= WB_MEM;
          end
        end

        FILL_MEM: begin
          if (!mem_busy_r) begin
            mem_req    <= 1'b1;
            mem_wr     <= 1'b0;
            mem_addr   <= {req_tag_r, req_idx_r, beat_word_s};
            mem_busy_r <= 1'b1;
          end else if (mem_ack) begin
            mem_req     <= 1'b0;
            mem_busy_r  <= 1'b0;
            set_data_in <= mem_rdata;
            state_r     <= FILL_WR;
          end else begin
            state_r <= FILL_MEM;
          end
        end

        FILL_WR: begin
          if (!set_busy_r) begin
            set_enable   <= 1'b1;
            set_comp     <= 1'b0;
            set_write    <= 1'b1;
            set_valid_in <= 1'b1;
            set_word     <= beat_word_s;
            set_tag_in   <= req_tag_r;
            set_busy_r   <= 1'b1;
          end else if (set_ack) begin
            set_enable   <= 1'b0;
            set_write    <= 1'b0;
            set_valid_in <= 1'b0;
            set_busy_r   <= 1'b0;
            if (last_word_s) begin
              word_cnt_r <= '0;
              replay_r   <= 1'b1;
              state_r    <= PROBE;
            end else begin
              word_cnt_r <= word_cnt_r + CNT_W'(1);
              state_r    <= FILL_MEM;
            end
          end else begin
            state_r <= FILL_WR;
          end
        end

        DONE: begin
          state_r <= IDLE;
        end

        default: begin
          set_enable <= 1'b0;
          mem_req    <= 1'b0;
          set_busy_r <= 1'b0;
          mem_busy_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
